// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encodings, line level and bit-timing helper
package uart_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_BREAK} uart_state_t;
    localparam logic LINE_IDLE = 1'b1;
    function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: counts 0..CYCLES_PER_BIT-1 and flags the last cycle of each bit
module uart_bit_timer #(
    parameter int CYCLES_PER_BIT = 434
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    output logic o_bit_done
);
    localparam int CW = $clog2(CYCLES_PER_BIT);
    logic [CW-1:0] r_count;
    assign o_bit_done = r_count == CW'(CYCLES_PER_BIT - 1);
    // free-running bit-cycle counter, wraps on bit_done, held at zero while cleared
    always_ff @(posedge clk) begin
        if (reset || i_clear || o_bit_done) r_count <= '0;
        else r_count <= r_count + 1'b1;
    end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: valid/ready UART transmitter producing start/data/stop frames and BREAK
module uart_tx
    import uart_pkg::*;
#(
    parameter int BIT_RATE     = 115200,
    parameter int CLK_HZ       = 50000000,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    uart_tx_valid,
    input  logic                    uart_tx_break,
    input  logic [PAYLOAD_BITS-1:0] uart_tx_data,
    output logic                    uart_tx_ready,
    output logic                    uart_tx_busy,
    output logic                    uart_txd
);
    localparam int CPB = cycles_per_bit(CLK_HZ, BIT_RATE);
    localparam int BW  = $clog2(PAYLOAD_BITS + STOP_BITS + 1);

    generate
        if (CPB < 2) begin : g_cpb_check
            $error("uart_tx: CLK_HZ/BIT_RATE must be at least 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_check
            $error("uart_tx: STOP_BITS must be 1 or 2");
        end
    endgenerate

    uart_state_t             r_state, w_state_next;
    logic [PAYLOAD_BITS-1:0] r_shift, w_shift_next;
    logic [BW-1:0]           r_bit_cnt, w_bit_cnt_next, w_last_idx;
    logic                    r_txd, w_txd_next;
    logic                    w_accept, w_bit_done, w_wrap;

    assign uart_tx_ready = (r_state == ST_IDLE) && !reset;
    assign w_accept      = uart_tx_valid && uart_tx_ready;
    assign uart_tx_busy  = r_state != ST_IDLE;
    assign uart_txd      = r_txd;

    uart_bit_timer #(.CYCLES_PER_BIT(CPB)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (r_state == ST_IDLE),
        .o_bit_done (w_bit_done)
    );

    // next state, shift register, bit counter and the line level for the next cycle
    always_comb begin
        w_state_next = r_state;
        w_shift_next = r_shift;
        w_last_idx = r_state == ST_DATA ? BW'(PAYLOAD_BITS - 1) :
                     r_state == ST_STOP ? BW'(STOP_BITS - 1) :
                     r_state == ST_BREAK ? BW'(PAYLOAD_BITS + STOP_BITS) : '0;
        w_wrap = w_bit_done && r_bit_cnt == w_last_idx;
        w_bit_cnt_next = !w_bit_done ? r_bit_cnt : w_wrap ? '0 : r_bit_cnt + 1'b1;
        case (r_state)
            ST_IDLE: if (w_accept) begin
                w_state_next = uart_tx_break ? ST_BREAK : ST_START;
                w_shift_next = uart_tx_data;
            end
            ST_START: if (w_bit_done) w_state_next = ST_DATA;
            ST_DATA: if (w_bit_done) begin
                w_shift_next = r_shift >> 1;
                w_state_next = w_wrap ? ST_STOP : ST_DATA;
            end
            ST_STOP: if (w_wrap) w_state_next = ST_IDLE;
            ST_BREAK: if (w_wrap) w_state_next = ST_STOP;
            default: w_state_next = ST_IDLE;
        endcase
        w_txd_next = w_state_next == ST_DATA ? w_shift_next[0] :
                     (w_state_next == ST_START || w_state_next == ST_BREAK) ? 1'b0 : LINE_IDLE;
    end

    // state registers; reset forces the line idle on the very next edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_txd     <= LINE_IDLE;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_txd     <= w_txd_next;
        end
    end
endmodule
